spike_rate_counter: RTL
=======================

SPIKE_RATE_COUNTER -- requirements
Module: spike_rate_counter

Interface
REQ-001 SHALL have parameter WINDOW, default 7168, meaning window length in clk cycles (legal range 2..65535).
REQ-002 SHALL have parameter CNT_WIDTH, default 14, meaning width of the spike count.
REQ-003 SHALL have parameter THRESH, default 16, meaning minimum window count that asserts fire_out.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port en  input  1  counting enable.
REQ-007 SHALL have port neuron_in  input  1  binary spike from the network output neuron, synchronous to clk.
REQ-008 SHALL have port count_out  output  CNT_WIDTH  spike count of the last closed window.
REQ-009 SHALL have port count_valid  output  1  count_out holds an unconsumed result.
REQ-010 SHALL have port count_ready  input  1  consumer accepts the result when high together with count_valid.
REQ-011 SHALL have port fire_out  output  1  count_out >= THRESH; qualified by count_valid.
REQ-012 SHALL have port overrun  output  1  sticky flag: a result was overwritten before it was accepted.

Function
REQ-013 SHALL detect a spike as a rising edge of neuron_in, using a registered copy of neuron_in; a high level held for N cycles counts once.
REQ-014 SHALL have two states: IDLE (en=0, window counter and accumulator held at 0) and COUNT.
REQ-015 SHALL move IDLE->COUNT on the first cycle en=1; that cycle is window cycle 0.
REQ-016 SHALL, in COUNT, advance the window counter 0..WINDOW-1 and wrap it to 0 after WINDOW-1 with no idle cycle between windows.
REQ-017 SHALL count an edge detected on cycle WINDOW-1 in the closing window; an edge on cycle 0 counts in the new window.
REQ-018 SHALL saturate the accumulator at 2^CNT_WIDTH-1; it does not wrap.
REQ-019 SHALL, on window close, load count_out and fire_out and set count_valid on the following cycle (latency 1); the accumulator restarts at 0, or at 1 if an edge occurs on cycle 0.
REQ-020 SHALL clear count_valid on the cycle after count_valid && count_ready; count_out holds its value.
REQ-021 SHALL, if a window closes while count_valid=1 and count_ready=0, overwrite count_out/fire_out, keep count_valid=1, and set overrun.
REQ-022 SHALL, if a window closes on the same cycle count_valid && count_ready, treat the old result as accepted, load the new one, keep count_valid=1, and leave overrun unchanged.
REQ-023 SHALL, on en=0 in COUNT, discard the partial window, go to IDLE next cycle, and leave count_out/count_valid/overrun unchanged.
REQ-024 SHALL clear overrun only on rst.

Reset
REQ-025 SHALL, with rst=1 at a rising clk edge, set state=IDLE, window counter=0, accumulator=0, edge register=0, count_out=0, count_valid=0, fire_out=0, overrun=0 (and peak_out=0 when present); rst has priority over en and count_ready.
REQ-026 SHALL, on rst asserted mid-window, discard the partial count; the first window after release starts on the first cycle with rst=0 and en=1.

Configuration
REQ-027 SHALL, when macro SPIKE_PEAK_HOLD_EN is defined, add output peak_out [CNT_WIDTH], updated 1 cycle after each window close to max(peak_out, closed count) and cleared only by rst.
REQ-028 SHALL, when SPIKE_PEAK_HOLD_EN is undefined, omit peak_out and its comparator; all other behaviour is identical.

Verification
REQ-029 SHALL cover steady rate: WINDOW=16, en=1, neuron_in toggling every 2 cycles (edge every 4) -> count_out=4, count_valid 1 cycle after cycle 15, fire_out=0 with THRESH=16.
REQ-030 SHALL cover held level: neuron_in high for 10 cycles inside one window -> count_out=1.
REQ-031 SHALL cover overrun: count_ready=0 across two closes with 3 then 5 edges -> count_out=5, count_valid=1, overrun=1; count_ready pulse -> count_valid=0 next cycle.
REQ-032 SHALL cover simultaneous accept and close: count_ready=1 on the close cycle -> new count loaded, count_valid stays 1, overrun=0.
REQ-033 SHALL cover saturation and abort: CNT_WIDTH=3, 9 edges -> count_out=7, fire_out=1 with THRESH=7; en=0 at cycle 5 of the next window -> no new result, count_out stays 7.
REQ-034 SHALL cover reset mid-window, with SPIKE_PEAK_HOLD_EN defined: windows of 6 then 2 edges -> peak_out=6; rst at cycle 8 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/spike_rate_counter.sv
// Counts rising edges of neuron_in over fixed windows of WINDOW clk cycles and hands each closed count
// to a valid/ready consumer. Optional peak-hold output is enabled by defining SPIKE_PEAK_HOLD_EN.
module spike_rate_counter #(
    parameter int unsigned WINDOW    = 7168,
    parameter int unsigned CNT_WIDTH = 14,
    parameter int unsigned THRESH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 neuron_in,
    output logic [CNT_WIDTH-1:0] count_out,
    output logic                 count_valid,
    input  logic                 count_ready,
    output logic                 fire_out,
    output logic                 overrun
`ifdef SPIKE_PEAK_HOLD_EN
    ,
    output logic [CNT_WIDTH-1:0] peak_out
`endif
);

    localparam int unsigned          WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_COUNT = 1'b1;

    logic [0:0]           state;
    logic [WIN_W-1:0]     win_cnt;
    logic [WIN_W-1:0]     win_idx;
    logic [CNT_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] acc_next;
    logic                 nin_q;
    logic                 spike;
    logic                 win_close;
    logic                 fire_next;
    logic                 accepted;

    assign spike = neuron_in & ~nin_q;

    // The first enabled cycle out of IDLE is window cycle 0.
    assign win_idx = (state == S_IDLE) ? '0 : win_cnt;

    // The count includes this cycle's edge, so an edge on the closing cycle lands in the closing window.
    assign acc_next  = (spike && (acc != CNT_MAX)) ? acc + CNT_WIDTH'(1) : acc;
    assign win_close = en && (win_idx == WIN_LAST);
    assign fire_next = 32'(acc_next) >= THRESH;
    assign accepted  = count_valid && count_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            win_cnt <= '0;
            acc     <= '0;
            nin_q   <= 1'b0;
        end else begin
            nin_q <= neuron_in;
            if (!en) begin
                state   <= S_IDLE;
                win_cnt <= '0;
                acc     <= '0;
            end else if (win_close) begin
                state   <= S_COUNT;
                win_cnt <= '0;
                acc     <= '0;
            end else begin
                state   <= S_COUNT;
                win_cnt <= win_idx + WIN_W'(1);
                acc     <= acc_next;
            end
        end
    end

    // A close with a pending result that is not being accepted on that same cycle overwrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_out   <= '0;
            fire_out    <= 1'b0;
            count_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (win_close) begin
            count_out   <= acc_next;
            fire_out    <= fire_next;
            count_valid <= 1'b1;
            if (count_valid && !count_ready) overrun <= 1'b1;
        end else if (accepted) begin
            count_valid <= 1'b0;
        end
    end

`ifdef SPIKE_PEAK_HOLD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_out <= '0;
        end else if (win_close && (acc_next > peak_out)) begin
            peak_out <= acc_next;
        end
    end
`endif

endmodule
